load_extend_ctrl: RTL

Sequencer for the load path of the CPU datapath. It accepts a load request (address, size, signedness) from the core, runs a req/ack read on the data memory port, selects the addressed byte/halfword lane and sign- or zero-extends it to 32 bits. It also flags misaligned accesses and memory timeouts. It sits between the core's memory stage and the data memory, and drives the extension step that the core otherwise performs combinationally.

---
 rtl/load_extend_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/load_extend_ctrl.sv
// Load-path sequencer: issues a req/ack read on the data memory port, then
// selects the addressed byte/halfword lane and sign- or zero-extends it to 32 bits.
module load_extend_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           rdata,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_t;

  state_t                state_q, state_d;
  logic [1:0]            off_q, off_d;
  size_t                 size_q, size_d;
  logic                  uns_q, uns_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  access_legal;

  // Selects the lane named by the byte offset and widens it to 32 bits.
  function automatic logic [31:0] extend_lane(
    input logic [31:0] word,
    input logic [1:0]  off,
    input size_t       sz,
    input logic        uns
  );
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    lane_b = word[8*off +: 8];
    lane_h = word[16*off[1] +: 16];
    case (sz)
      SZ_BYTE: result = {{24{lane_b[7] & ~uns}}, lane_b};
      SZ_HALF: result = {{16{lane_h[15] & ~uns}}, lane_h};
      default: result = word;
    endcase
    return result;
  endfunction

  always_comb begin
    case (size_t'(size))
      SZ_BYTE:  access_legal = 1'b1;
      SZ_HALF:  access_legal = ~addr[0];
      SZ_WORD:  access_legal = (addr[1:0] == 2'b00);
      default:  access_legal = 1'b0;
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (access_legal) begin
            state_d    = REQ;
            off_d      = addr[1:0];
            size_d     = size_t'(size);
            uns_d      = is_unsigned;
            cnt_d      = '0;
            mem_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
          end else begin
            err_d = 1'b1;
          end
        end
      end

      REQ: begin
        // An ack in the final allowed cycle beats the timeout.
        if (mem_ack) begin
          state_d = IDLE;
          rdata_d = extend_lane(mem_rdata, off_q, size_q, uns_q);
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      off_q      <= 2'b00;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      rdata_q    <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // mem_req and busy are exactly "in REQ", taken straight from the state flop.
  assign mem_req  = (state_q == REQ);
  assign busy     = (state_q == REQ);
  assign mem_addr = mem_addr_q;
  assign rdata    = rdata_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
